// File: rtl/uart_pkg.sv
// Shared UART types and baud timing helpers, common to the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    typedef logic [7:0] byte_t;

    function automatic int clks_per_bit(input int freq, input int bauds);
        return freq / bauds;
    endfunction

endpackage

// File: rtl/uart_receiver_sync_fifo.sv
// Small show-ahead FIFO; a push while full is accepted only if a pop frees a slot the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, shift register and receive FIFO.
// state | meaning
// IDLE  | line high, waiting for a falling edge
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first, one per bit time
// STOP  | sampling the stop bit; high pushes the byte, low is a framing error
// BREAK | line held low after a framing error; wait for it to return high
module uart_receiver
    import uart_pkg::*;
#(
    parameter int FREQ_HZ    = 12000000,
    parameter int BAUDS      = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam int CPB  = clks_per_bit(FREQ_HZ, BAUDS);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

    logic [1:0]    r_sync;
    rx_state_t     r_state;
    rx_state_t     w_state_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    byte_t         r_shift;
    logic          r_frame_err;
    logic          r_overrun;
    logic          w_rx_s;
    logic          w_cnt_clr;
    logic          w_sample;
    logic          w_push;
    logic          w_frame_err;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_sync  <= 2'b11;
            r_state <= IDLE;
        end else begin
            r_sync  <= {r_sync[0], rx_i};
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_sample     = 1'b0;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = START;
                    w_cnt_clr    = 1'b1;
                end
            end
            START: begin
                if (r_cnt == CNT_HALF_END) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_next = STOP;
                end
            end
            STOP: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        w_push       = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rx_s) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bit index is held at zero outside DATA so every frame starts from bit 0.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
            if (r_state != DATA) r_bit_idx <= '0;
            else if (w_sample)   r_bit_idx <= r_bit_idx + 3'd1;
            if (w_sample) r_shift <= {w_rx_s, r_shift[7:1]};
            r_frame_err <= w_frame_err;
            r_overrun   <= w_push && w_full && !w_pop;
        end
    end

    assign w_pop       = valid_o && ready_i;
    assign valid_o     = !w_empty;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_i(reset_i),
        .push   (w_push),
        .din    (r_shift),
        .pop    (w_pop),
        .dout   (data_o),
        .empty  (w_empty),
        .full   (w_full)
    );

endmodule
